// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcode map, instruction
// field positions and the sequencer state encoding.
package core_pkg;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] ALU_MAX = 4'hB;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RI_MSB  = 11;
    localparam int RI_LSB  = 8;
    localparam int RJ_MSB  = 7;
    localparam int RJ_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        ISSUE    = 3'd3,
        WAIT_ALU = 3'd4,
        HALTED   = 3'd5
    } fdcState_e;

    function automatic logic isAluOp(input logic [3:0] op);
        return (op <= ALU_MAX);
    endfunction

endpackage

// File: rtl/fdc_watchdog.sv
// Cycle counter guarding the wait for the ALU FSM; expired is raised on the
// TIMEOUT-th enabled cycle after a clear.
module fdc_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Counter saturates at its last value so it can never alias back to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_LAST)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == CNT_LAST);

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Instruction fetch/decode sequencer: resolves control flow locally and hands
// ALU-class instructions to the ALU FSM, guarded by a watchdog.
module fetch_decode_ctrl
    import core_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [15:0]     imem_data,
    input  logic            imem_valid,
    input  logic            zero_flag,
    output logic            ALUstr,
    output logic [3:0]      opCode,
    output logic [3:0]      regI,
    output logic [3:0]      regJ,
    input  logic            aluDone,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    fdcState_e       state_r;
    fdcState_e       nextState_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pcNext_s;
    logic [15:0]     instr_r;
    logic [3:0]      opCode_r;
    logic [3:0]      regI_r;
    logic [3:0]      regJ_r;
    logic            aluStr_r;
    logic            imemRd_r;
    logic            halted_r;
    logic            err_r;
    logic            errSet_s;
    logic            wdClear_s;
    logic            wdEnable_s;
    logic            wdExpired_s;

    logic [3:0]      instrOp_s;
    logic [PC_W-1:0] instrImm_s;
    logic [PC_W-1:0] pcInc_s;

    assign instrOp_s  = instr_r[OP_MSB:OP_LSB];
    assign instrImm_s = PC_W'(instr_r[IMM_MSB:IMM_LSB]);
    assign pcInc_s    = pc_r + PC_ONE;
    assign wdClear_s  = (state_r == ISSUE);
    assign wdEnable_s = (state_r == WAIT_ALU);

    fdc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdClear_s),
        .enable  (wdEnable_s),
        .expired (wdExpired_s)
    );

    // Next-state and next-pc decision for every sequencer state.
    always_comb begin
        nextState_s = state_r;
        pcNext_s    = pc_r;
        errSet_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    nextState_s = FETCH;
                end else begin
                    nextState_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    nextState_s = DECODE;
                end else begin
                    nextState_s = FETCH;
                end
            end
            DECODE: begin
                if (isAluOp(instrOp_s)) begin
                    nextState_s = ISSUE;
                end else if (instrOp_s == OP_HALT) begin
                    nextState_s = HALTED;
                end else begin
                    case (instrOp_s)
                        OP_JMP:  pcNext_s = instrImm_s;
                        OP_BZ:   pcNext_s = zero_flag ? instrImm_s : pcInc_s;
                        OP_NOP:  pcNext_s = pcInc_s;
                        default: pcNext_s = pcInc_s;
                    endcase
                    nextState_s = run ? FETCH : IDLE;
                end
            end
            ISSUE: begin
                nextState_s = WAIT_ALU;
            end
            WAIT_ALU: begin
                // A completion in the expiry cycle still counts as success.
                if (aluDone) begin
                    pcNext_s    = pcInc_s;
                    nextState_s = run ? FETCH : IDLE;
                end else if (wdExpired_s) begin
                    errSet_s    = 1'b1;
                    nextState_s = HALTED;
                end else begin
                    nextState_s = WAIT_ALU;
                end
            end
            HALTED: begin
                nextState_s = HALTED;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            pc_r    <= '0;
            instr_r <= 16'h0000;
        end else begin
            state_r <= nextState_s;
            pc_r    <= pcNext_s;
            if ((state_r == FETCH) && imem_valid) begin
                instr_r <= imem_data;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aluStr_r <= 1'b0;
            imemRd_r <= 1'b0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            opCode_r <= 4'h0;
            regI_r   <= 4'h0;
            regJ_r   <= 4'h0;
        end else begin
            aluStr_r <= (nextState_s == ISSUE);
            imemRd_r <= (nextState_s == FETCH);
            halted_r <= (nextState_s == HALTED);
            err_r    <= err_r | errSet_s;
            if ((state_r == DECODE) && isAluOp(instrOp_s)) begin
                opCode_r <= instrOp_s;
                regI_r   <= instr_r[RI_MSB:RI_LSB];
                regJ_r   <= instr_r[RJ_MSB:RJ_LSB];
            end else begin
                opCode_r <= opCode_r;
                regI_r   <= regI_r;
                regJ_r   <= regJ_r;
            end
        end
    end

    assign imem_addr = pc_r;
    assign imem_rd   = imemRd_r;
    assign ALUstr    = aluStr_r;
    assign opCode    = opCode_r;
    assign regI      = regI_r;
    assign regJ      = regJ_r;
    assign pc        = pc_r;
    assign halted    = halted_r;
    assign err       = err_r;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: inputs driven and outputs sampled on
// the falling edge, expected values worked out by hand.
module tb_fetch_decode_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        zero_flag;
    logic        ALUstr;
    logic [3:0]  opCode;
    logic [3:0]  regI;
    logic [3:0]  regJ;
    logic        aluDone;
    logic [7:0]  pc;
    logic        halted;
    logic        err;

    int assertCount = 0;
    int failCount   = 0;

    fetch_decode_ctrl #(
        .PC_W    (8),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .zero_flag  (zero_flag),
        .ALUstr     (ALUstr),
        .opCode     (opCode),
        .regI       (regI),
        .regJ       (regJ),
        .aluDone    (aluDone),
        .pc         (pc),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b0;
        run   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Wait (bounded) for a fetch request, then answer it after 'latency' cycles.
    // Returns on the falling edge while the sequencer is in DECODE.
    task automatic fetchInstr(input logic [15:0] instr, input int latency);
        int n;
        n = 0;
        while ((imem_rd !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        checkEq("fetch_req", imem_rd, 1);
        repeat (latency - 1) tick();
        imem_valid = 1'b1;
        imem_data  = instr;
        tick();
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
    endtask

    int strCount;
    int rdSeen;

    initial begin
        reset = 1'b0; run = 1'b0; imem_data = 16'h0000; imem_valid = 1'b0;
        zero_flag = 1'b0; aluDone = 1'b0;
        tick();
        tick();
        checkEq("rst_pc", pc, 0);
        checkEq("rst_imem_rd", imem_rd, 0);
        checkEq("rst_alustr", ALUstr, 0);
        checkEq("rst_opcode", {opCode, regI, regJ}, 0);
        checkEq("rst_halted_err", {halted, err}, 0);
        reset = 1'b1;
        tick();
        checkEq("idle_no_fetch", imem_rd, 0);

        // ALU op 0x3120 answered after 2 cycles, aluDone ten cycles later
        run = 1'b1;
        fetchInstr(16'h3120, 2);
        strCount = 0; rdSeen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) checkEq("alu_str_decode", ALUstr, 0);
            if (i == 1) begin
                checkEq("alu_str_issue", ALUstr, 1);
                checkEq("alu_opcode", opCode, 4'h3);
                checkEq("alu_regs", {regI, regJ}, 8'h12);
            end
            strCount += int'(ALUstr);
            rdSeen   += int'(imem_rd);
            tick();
        end
        checkEq("alu_opcode_stable", opCode, 4'h3);
        aluDone = 1'b1;
        tick();
        aluDone = 1'b0;
        checkEq("alu_str_count", strCount, 1);
        checkEq("alu_no_fetch_wait", rdSeen, 0);
        checkEq("alu_pc", pc, 8'h01);
        checkEq("alu_refetch", {imem_rd, imem_addr}, {1'b1, 8'h01});

        // JMP 0x40, then BZ taken and not taken
        fetchInstr(16'hC040, 1);
        strCount = int'(ALUstr);
        tick();
        strCount += int'(ALUstr);
        checkEq("jmp_pc", pc, 8'h40);
        checkEq("jmp_no_alustr", strCount, 0);
        zero_flag = 1'b1;
        fetchInstr(16'hD010, 1);
        tick();
        checkEq("bz_taken_pc", pc, 8'h10);
        zero_flag = 1'b0;
        fetchInstr(16'hD010, 1);
        tick();
        checkEq("bz_not_taken_pc", pc, 8'h11);

        // NOP at 0xFF wraps the PC
        fetchInstr(16'hC0FF, 1);
        tick();
        checkEq("jmp_ff_pc", pc, 8'hFF);
        fetchInstr(16'hE000, 1);
        tick();
        checkEq("nop_wrap_pc", pc, 8'h00);
        checkEq("nop_wrap_addr", {imem_rd, imem_addr}, {1'b1, 8'h00});

        // Watchdog: aluDone never arrives
        fetchInstr(16'h5670, 1);
        tick();
        repeat (64) tick();
        checkEq("wd_before_expiry", {halted, err}, 0);
        tick();
        checkEq("wd_expired", {halted, err}, 2'b11);
        checkEq("wd_pc_held", pc, 8'h00);
        rdSeen = 0;
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b1; aluDone = 1'b1; imem_data = 16'hE000;
            tick();
            rdSeen += int'(imem_rd);
        end
        imem_valid = 1'b0; aluDone = 1'b0;
        checkEq("halted_no_fetch", rdSeen, 0);
        checkEq("halted_sticky", {halted, err, pc}, {2'b11, 8'h00});

        // HALT opcode
        doReset();
        checkEq("rst_clears_err", {halted, err}, 0);
        run = 1'b1;
        fetchInstr(16'hF000, 1);
        tick();
        checkEq("halt_state", {halted, err}, 2'b10);
        checkEq("halt_pc", pc, 8'h00);
        rdSeen = 0;
        for (int i = 0; i < 5; i++) begin
            imem_valid = (i % 2) == 0;
            tick();
            rdSeen += int'(imem_rd);
        end
        imem_valid = 1'b0;
        checkEq("halt_no_fetch", rdSeen, 0);

        // aluDone on the final watchdog cycle wins
        doReset();
        run = 1'b1;
        fetchInstr(16'h1230, 1);
        tick();
        repeat (64) tick();
        aluDone = 1'b1;
        tick();
        aluDone = 1'b0;
        checkEq("wd_edge_no_err", {halted, err}, 0);
        checkEq("wd_edge_pc", pc, 8'h01);
        checkEq("wd_edge_refetch", imem_rd, 1);

        // Reset in the middle of WAIT_ALU
        fetchInstr(16'h2340, 1);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        checkEq("midrst_pc", pc, 0);
        checkEq("midrst_outs", {ALUstr, imem_rd, halted, err, opCode, regI, regJ}, 0);
        reset = 1'b1;
        tick();
        checkEq("midrst_refetch", {imem_rd, imem_addr}, {1'b1, 8'h00});

        // run dropped mid-instruction: finish, then park in IDLE
        fetchInstr(16'h4560, 1);
        tick(); tick();
        run = 1'b0;
        tick();
        aluDone = 1'b1;
        tick();
        aluDone = 1'b0;
        checkEq("runoff_pc", pc, 8'h01);
        checkEq("runoff_idle", imem_rd, 0);
        tick();
        checkEq("runoff_parked", {imem_rd, halted, opCode}, {1'b0, 1'b0, 4'h4});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
